sel_sequencer: RTL and testbench

//   Upstream driver for the board's 4:1 data selector. It produces the
//   2-bit select code from a bouncy pushbutton, with an optional automatic

---
 rtl/sel_sequencer.sv | 67 ++++++
 tb/tb_sel_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sel_sequencer.sv
// sel_sequencer: debounced pushbutton / auto-step driver for a 4:1 selector select code
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset (synchronous release expected)
//   btn_raw    raw bouncy pushbutton, active-high, asynchronous
//   auto_en    1 = step automatically every AUTO_PERIOD cycles
//   dir        step direction: 0 = up, 1 = down
//   sel        select code, wraps modulo 2**SEL_W
//   sel_chg    one-cycle strobe after each step
//   btn_level  debounced button level
//   onehot     one-hot LED view of sel
module sel_sequencer #(
   parameter int DEB_CYCLES  = 20,
   parameter int AUTO_PERIOD = 50_000_000,
   parameter int SEL_W       = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  btn_raw,
   input  logic                  auto_en,
   input  logic                  dir,
   output logic [SEL_W-1:0]      sel,
   output logic                  sel_chg,
   output logic                  btn_level,
   output logic [2**SEL_W-1:0]   onehot
);
   localparam int DW = $clog2(DEB_CYCLES);
   localparam int AW = $clog2(AUTO_PERIOD);
   localparam int N  = 2**SEL_W;
   logic          s1, btn_s;
   logic [DW-1:0] deb_cnt, deb_nxt;
   logic [AW-1:0] tmr, tmr_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic          deb_done, press, tick, step;
   always_comb begin
      deb_done = (btn_s != btn_level) && (deb_cnt == DW'(DEB_CYCLES - 1));
      deb_nxt  = (btn_s == btn_level || deb_done) ? '0 : deb_cnt + DW'(1);
      // press event coincides with the edge where btn_level rises
      press    = deb_done && !btn_level;
      tick     = auto_en && (tmr == AW'(AUTO_PERIOD - 1));
      step     = press || tick;
      // a press in auto mode restarts the period; coincident press+tick is one step
      tmr_nxt  = (!auto_en || step) ? '0 : tmr + AW'(1);
      sel_nxt  = step ? (dir ? sel - SEL_W'(1) : sel + SEL_W'(1)) : sel;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         btn_s     <= 1'b0;
         deb_cnt   <= '0;
         btn_level <= 1'b0;
         tmr       <= '0;
         sel       <= '0;
         sel_chg   <= 1'b0;
         onehot    <= N'(1);
      end else begin
         s1        <= btn_raw;
         btn_s     <= s1;
         deb_cnt   <= deb_nxt;
         btn_level <= btn_level ^ deb_done;
         tmr       <= tmr_nxt;
         sel       <= sel_nxt;
         sel_chg   <= step;
         onehot    <= N'(1) << sel_nxt;
      end
   end
endmodule

// File: tb/tb_sel_sequencer.sv
// tb_sel_sequencer: table, directed and random checks of sel_sequencer against a history-based model
module tb_sel_sequencer;
   localparam int DEB  = 4;
   localparam int AUTO = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn_raw = 1'b0;
   logic       auto_en = 1'b0;
   logic       dir = 1'b0;
   logic [1:0] sel;
   logic       sel_chg;
   logic       btn_level;
   logic [3:0] onehot;

   int n_vec = 0;
   int n_bad = 0;

   sel_sequencer #(.DEB_CYCLES(DEB), .AUTO_PERIOD(AUTO), .SEL_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .auto_en(auto_en), .dir(dir),
      .sel(sel), .sel_chg(sel_chg), .btn_level(btn_level), .onehot(onehot)
   );

   always #5 clk = ~clk;

   // model: raw-sample history (newest first), debounced level, select, timer age
   bit m_hist[$];
   bit m_lvl;
   bit m_chg;
   int m_sel;
   int m_since;

   typedef struct packed {
      logic       raw;
      logic       ae;
      logic       d;
      logic [1:0] e_sel;
      logic       e_chg;
      logic       e_lvl;
   } vec_t;

   // clean hold for 7 edges then release for 6 edges, starting from reset
   vec_t tbl [13] = '{
      '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0}
   };

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
      chk({tag, "_onehot"}, 32'(onehot), 32'(1) << m_sel);
      chk({tag, "_chg"}, 32'(sel_chg), 32'(m_chg));
      chk({tag, "_lvl"}, 32'(btn_level), 32'(m_lvl));
   endtask

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i <= DEB; i++) m_hist.push_back(1'b0);
      m_lvl = 1'b0;
      m_chg = 1'b0;
      m_sel = 0;
      m_since = 0;
   endtask

   // level flips once the last DEB synchronised samples all disagree with it;
   // the synchroniser makes the sample seen at edge e the raw value from edge e-2
   task automatic model_edge(input bit raw, input bit ae, input bit d);
      bit all_diff, press, tick, stp;
      all_diff = 1'b1;
      for (int i = 1; i <= DEB; i++) if (m_hist[i] == m_lvl) all_diff = 1'b0;
      press = all_diff && !m_lvl;
      if (all_diff) m_lvl = !m_lvl;
      tick = ae && (m_since == AUTO - 1);
      stp = press || tick;
      m_since = (!ae || stp) ? 0 : m_since + 1;
      if (stp) m_sel = (m_sel + (d ? 3 : 1)) % 4;
      m_chg = stp;
      m_hist.push_front(raw);
      void'(m_hist.pop_back());
   endtask

   task automatic cyc(input logic raw, input logic ae, input logic d);
      btn_raw = raw;
      auto_en = ae;
      dir = d;
      @(posedge clk);
      model_edge(raw, ae, d);
      #1;
      check_all("cyc");
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic press(input logic d);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, d);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, d);
   endtask

   initial begin
      bit seen, r, a;
      #2;
      do_reset();

      // 1: table-driven hold/release
      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].raw, tbl[i].ae, tbl[i].d);
         chk($sformatf("t1_sel[%0d]", i), 32'(sel), 32'(tbl[i].e_sel));
         chk($sformatf("t1_chg[%0d]", i), 32'(sel_chg), 32'(tbl[i].e_chg));
         chk($sformatf("t1_lvl[%0d]", i), 32'(btn_level), 32'(tbl[i].e_lvl));
      end

      // 2: bounce every 2 cycles is rejected
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(((i / 2) % 2) == 0, 1'b0, 1'b0);
         seen |= sel_chg;
         chk("t2_lvl", 32'(btn_level), 32'd0);
      end
      cyc(1'b0, 1'b0, 1'b0);
      chk("t2_chg_seen", 32'(seen), 32'd0);
      chk("t2_sel", 32'(sel), 32'd1);

      // 3: up presses with wrap, then down wrap
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         press(1'b0);
         chk($sformatf("t3_up%0d", k), 32'(sel), 32'(k % 4));
      end
      press(1'b1);
      chk("t3_down_wrap", 32'(sel), 32'd3);

      // 4: auto stepping, freeze, restart from zero
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         chk("t4_chg", 32'(sel_chg), 32'(i % 8 == 7));
      end
      chk("t4_sel", 32'(sel), 32'd3);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
      chk("t4_frozen", 32'(sel), 32'd3);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         chk("t4_restart_chg", 32'(sel_chg), 32'(i == 7));
      end
      chk("t4_restart_sel", 32'(sel), 32'd0);
      cyc(1'b0, 1'b0, 1'b0);

      // 5: press coincident with tick gives a single step
      for (int i = 0; i < 16; i++) begin
         cyc(i >= 2, 1'b1, 1'b0);
         chk("t5_chg", 32'(sel_chg), 32'(i == 7 || i == 15));
         chk("t5_lvl", 32'(btn_level), 32'(i >= 7));
         if (i == 7) chk("t5_single", 32'(sel), 32'd1);
      end
      chk("t5_next", 32'(sel), 32'd2);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);

      // 6: reset mid-debounce discards progress
      do_reset();
      press(1'b0);
      press(1'b0);
      chk("t6_pre", 32'(sel), 32'd2);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
      do_reset();
      chk("t6_rst_sel", 32'(sel), 32'd0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         chk("t6_hold", 32'(sel), 32'(i == 5));
      end
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);

      // random: slow-changing button and mode, random direction
      r = 1'b0;
      a = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(5) == 0) r = !r;
         if ($urandom_range(39) == 0) a = !a;
         cyc(r, a, 1'($urandom_range(1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
